// File: rtl/fetch_stage_if.sv
// fetch_stage_if: redirect, instruction-memory and IF/ID signal bundle of the fetch stage
interface fetch_stage_if;
    logic        stall;
    logic [1:0]  redirect_kind;
    logic [63:0] redirect_base_pc;
    logic [31:0] redirect_instr;
    logic [63:0] redirect_reg;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [63:0] ifid_pc;
    logic [63:0] ifid_pc_plus4;
    logic [15:0] flush_count;
    modport master (
        output stall, redirect_kind, redirect_base_pc, redirect_instr, redirect_reg, imem_instr,
        input  imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4, flush_count
    );
    modport slave (
        input  stall, redirect_kind, redirect_base_pc, redirect_instr, redirect_reg, imem_instr,
        output imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4, flush_count
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, branch-target redirect and IF/ID pipeline register
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input logic          clk,
    input logic          reset,
    fetch_stage_if.slave bus
);
    logic [63:0] r_pc;
    logic        r_ifid_valid;
    logic [31:0] r_ifid_instr;
    logic [63:0] r_ifid_pc;
    logic [63:0] r_ifid_pc_plus4;
    logic [15:0] r_flush_count;
    logic [63:0] w_pc_plus4;
    logic [63:0] w_br_off;
    logic [63:0] w_cond_off;
    logic [63:0] w_target;
    logic        w_redirect;
    // Word-scaled sign-extended branch offsets and the selected redirect target
    always_comb begin
        w_pc_plus4 = r_pc + 64'd4;
        w_br_off   = {{36{bus.redirect_instr[25]}}, bus.redirect_instr[25:0], 2'b00};
        w_cond_off = {{43{bus.redirect_instr[23]}}, bus.redirect_instr[23:5], 2'b00};
        w_redirect = |bus.redirect_kind;
        w_target   = (bus.redirect_kind == 2'b01) ? bus.redirect_base_pc + w_br_off :
                     (bus.redirect_kind == 2'b10) ? bus.redirect_base_pc + w_cond_off :
                     {bus.redirect_reg[63:2], 2'b00};
    end
    // Redirect flushes IF/ID and beats stall; stall freezes everything; otherwise fetch advances
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc            <= RESET_PC;
            r_ifid_valid    <= 1'b0;
            r_ifid_instr    <= 32'd0;
            r_ifid_pc       <= 64'd0;
            r_ifid_pc_plus4 <= 64'd0;
            r_flush_count   <= 16'd0;
        end else if (w_redirect) begin
            r_pc            <= w_target;
            r_ifid_valid    <= 1'b0;
            r_ifid_instr    <= 32'd0;
            r_ifid_pc       <= 64'd0;
            r_ifid_pc_plus4 <= 64'd0;
            r_flush_count   <= r_flush_count + {15'd0, ~&r_flush_count};
        end else if (!bus.stall) begin
            r_pc            <= w_pc_plus4;
            r_ifid_valid    <= 1'b1;
            r_ifid_instr    <= bus.imem_instr;
            r_ifid_pc       <= r_pc;
            r_ifid_pc_plus4 <= w_pc_plus4;
        end
    end
    assign bus.imem_addr     = r_pc;
    assign bus.ifid_valid    = r_ifid_valid;
    assign bus.ifid_instr    = r_ifid_instr;
    assign bus.ifid_pc       = r_ifid_pc;
    assign bus.ifid_pc_plus4 = r_ifid_pc_plus4;
    assign bus.flush_count   = r_flush_count;
endmodule
